// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//
// Owns the PC and drives a synchronous-read instruction memory that returns
// data one cycle after the read strobe. Supports sequential fetch, PC-relative
// branch redirects, absolute jump redirects, a level halt request and a
// decode-side stall. A one-entry skid buffer catches the in-flight word when
// decode stalls, so nothing issued is ever dropped or repeated.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   imem_addr    fetch address (the PC register; RESET_VEC while in reset)
//   imem_en      read strobe; data appears on imem_rdata the next cycle
//   imem_rdata   memory read data
//   instr        instruction to decode (0 when instr_valid=0)
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc valid
//   dec_ready    decode accepts instr this cycle
//   br_taken     branch redirect request
//   br_pc        PC of the branch instruction
//   br_off       signed branch offset
//   jmp          jump redirect request (wins over br_taken)
//   jmp_target   absolute jump target
//   halt_req     level request to stop issuing fetches
//   halted       high while the FSM is in HALT
//
// Handshake: an instruction transfers to decode in every cycle where
// instr_valid && dec_ready are both high. While instr_valid is high and
// dec_ready is low, instr and instr_pc hold steady until accepted, unless a
// redirect or reset discards them.

module fetch_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter int                 OFF_W     = 8,
    parameter int                 PC_STEP   = 2,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               dec_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [OFF_W-1:0]   br_off,
    input  logic               jmp,
    input  logic [ADDR_W-1:0]  jmp_target,
    input  logic               halt_req,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    pc;
    logic                 inflight_valid;
    logic [ADDR_W-1:0]    inflight_pc;
    logic                 skid_valid;
    logic [ADDR_W-1:0]    skid_pc;
    logic [INSTR_W-1:0]   skid_instr;

    logic                 redirect;
    logic                 issue;
    logic                 stall_capture;
    logic [ADDR_W-1:0]    br_off_ext;
    logic [ADDR_W-1:0]    target;
    logic                 out_valid;

    always_comb begin
        br_off_ext    = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
        redirect      = jmp | br_taken;
        target        = jmp ? jmp_target : (br_pc + STEP + br_off_ext);
        // A new fetch is only safe when its data has somewhere to land next
        // cycle: skid empty and the current in-flight word not stalled.
        issue         = reset && (state == RUN) && !halt_req && !redirect &&
                        !skid_valid && !(inflight_valid && !dec_ready);
        stall_capture = inflight_valid && !skid_valid && !dec_ready;
        out_valid     = skid_valid || inflight_valid;
    end

    always_comb begin
        imem_en     = issue;
        imem_addr   = reset ? pc : RESET_VEC;
        instr_valid = reset && out_valid && !redirect;
        halted      = reset && (state == HALT);
        instr       = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            if (skid_valid) begin
                instr    = skid_instr;
                instr_pc = skid_pc;
            end else begin
                instr    = imem_rdata;
                instr_pc = inflight_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc             <= RESET_VEC;
            state          <= RUN;
            inflight_valid <= 1'b0;
            inflight_pc    <= RESET_VEC;
            skid_valid     <= 1'b0;
            skid_pc        <= '0;
            skid_instr     <= '0;
        end else begin
            case (state)
                RUN:     if (halt_req)  state <= HALT;
                HALT:    if (!halt_req) state <= RUN;
                default: state <= RUN;
            endcase

            if (redirect) begin
                // Everything fetched down the old path is discarded.
                pc             <= target;
                inflight_valid <= 1'b0;
                skid_valid     <= 1'b0;
            end else begin
                inflight_valid <= issue;
                if (issue) begin
                    pc          <= pc + STEP;
                    inflight_pc <= pc;
                end
                if (stall_capture) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= inflight_pc;
                    skid_instr <= imem_rdata;
                end else if (skid_valid && dec_ready) begin
                    skid_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage. It succeeds the fixed 16-bit PC register plus 2:1 next-PC mux.
- It owns the PC and drives a synchronous-read instruction memory (1-cycle latency).
- It supports sequential, branch (PC-relative) and jump (absolute) next-PC modes, halt, and a decode-side stall.
- It sits between instruction_memory and decode. A 1-entry skid buffer keeps in-flight fetches intact across stalls.

Parameters:
- ADDR_W, 16, PC / address width.
- INSTR_W, 16, instruction width.
- OFF_W, 8, branch offset width (signed).
- PC_STEP, 2, sequential PC increment.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch address; equals the PC register.
- imem_en  out  1  read strobe; data returns on imem_rdata the next cycle.
- imem_rdata  in  INSTR_W  memory read data.
- instr  out  INSTR_W  instruction to decode; 0 when instr_valid=0.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- dec_ready  in  1  decode accepts instr this cycle.
- br_taken  in  1  branch redirect request.
- br_pc  in  ADDR_W  PC of the branch instruction.
- br_off  in  OFF_W  signed branch offset.
- jmp  in  1  jump redirect request.
- jmp_target  in  ADDR_W  absolute jump target.
- halt_req  in  1  level; stop issuing new fetches.
- halted  out  1  high in HALT state.

Behaviour:
- Reset: while reset==0 at a posedge:
  - pc<=RESET_VEC, state<=RUN, inflight and skid invalidated.
  - imem_en is forced 0 during any cycle with reset==0.
  - Outputs during reset: instr_valid=0, instr=0, halted=0, imem_addr=RESET_VEC.
  - Reset mid-operation discards all in-flight and buffered data.
- State machine:
  - RUN -> HALT when halt_req=1.
  - HALT -> RUN when halt_req=0.
  - halted=1 iff state==HALT (registered).
- Issue:
  - Condition: issue = reset && state==RUN && !halt_req && !redirect && !skid_valid && !(inflight_valid && !dec_ready).
  - imem_en=issue.
  - On issue: pc<=pc+PC_STEP (mod 2^ADDR_W, wraps to 0 silently), inflight_valid<=1, inflight_pc<=pc. Otherwise inflight_valid<=0, unless the inflight entry is held.
- Output selection:
  - If skid_valid: instr=skid_instr, instr_pc=skid_pc.
  - Else if inflight_valid: instr=imem_rdata, instr_pc=inflight_pc.
  - instr_valid=(skid_valid|inflight_valid) && !redirect.
- Stall:
  - inflight_valid && !skid_valid && !dec_ready: capture imem_rdata/inflight_pc into skid, clear inflight.
  - skid_valid && dec_ready: skid drains. No issue occurs in the same cycle (issue requires !skid_valid).
- Redirect:
  - redirect = jmp|br_taken.
  - Jump has priority: target=jmp_target.
  - Branch target = br_pc + PC_STEP + sign_extend(br_off), truncated to ADDR_W.
  - In the redirect cycle: instr_valid=0, skid and inflight cleared, pc<=target, no issue.
  - Target presented on imem_addr with imem_en=1 at cycle R+1; instr_valid with instr_pc=target at cycle R+2. Redirect penalty is 2 cycles.
- Redirect during HALT: pc updated, state stays HALT, no issue until halt_req=0.
- Halt: already-issued fetches still deliver to decode. Resume reissues from the current pc with no skipped or duplicated addresses.
- Steady state (dec_ready=1, no redirect/halt): one instruction per cycle, first valid 2 cycles after reset release.
- Each instruction is delivered exactly once, in PC order between redirects.

Test Plan:
- Reset then run:
  - Stimulus: reset=0 for 2 cycles, then 1; memory holds mem[a]=a^16'hA5A5; dec_ready=1.
  - Required: imem_addr sequence 0,2,4,…; instr_valid first high 2 cycles after release with instr_pc=0, instr=16'hA5A5; then one instruction per cycle.
- Stall:
  - Stimulus: drop dec_ready for 3 cycles mid-stream at instr_pc=6.
  - Required: instr_pc=6 held valid throughout; imem_en=0 while the skid is full; after release, 6,8,10 delivered with no gap loss or duplication.
- Jump:
  - Stimulus: assert jmp=1, jmp_target=0x0100 together with br_taken=1.
  - Required: instr_valid=0 that cycle; imem_addr=0x0100 next cycle; instr_pc=0x0100 two cycles later (jump wins).
- Branch:
  - Stimulus: br_pc=0x0010, br_off=8'hF8.
  - Required: target 0x000A.
  - Stimulus: br_pc=0xFFFE, br_off=8'h04.
  - Required: target 0x0004 (wrap).
- Halt:
  - Stimulus: halt_req=1 for 4 cycles.
  - Required: halted=1 the following cycle; pending instruction still delivered; no imem_en; resume continues at the next sequential PC.
- Reset mid-stall:
  - Stimulus: reset=0 while the skid is full.
  - Required: instr_valid=0 next cycle; restart from RESET_VEC.
